// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle for the program loader.
// slave = loader side, master = host/link side.
interface imem_loader_if #(
    parameter int SIZE_INST = 5
);
    logic                 start;
    logic [7:0]           byte_data;
    logic                 byte_valid;
    logic                 byte_ready;
    logic                 imem_we;
    logic [SIZE_INST-1:0] imem_waddr;
    logic [31:0]          imem_wdata;
    logic                 cpu_hold;
    logic                 busy;
    logic                 done;
    logic                 load_ok;

    modport slave (
        input  start, byte_data, byte_valid,
        output byte_ready, imem_we, imem_waddr, imem_wdata,
        output cpu_hold, busy, done, load_ok
    );

    modport master (
        output start, byte_data, byte_valid,
        input  byte_ready, imem_we, imem_waddr, imem_wdata,
        input  cpu_hold, busy, done, load_ok
    );
endinterface

// File: rtl/imem_loader.sv
// Loads the instruction memory from a framed byte stream:
// count, little-endian words, XOR checksum. Holds the CPU while loading.
module imem_loader #(
    parameter int SIZE_INST = 5
) (
    input logic          clk,
    input logic          reset_n,
    imem_loader_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, COUNT, DATA, WRITE, CHECK, DONE
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [7:0]           n_words;
    logic [8:0]           wr_cnt;
    logic [8:0]           total;
    logic [8:0]           wr_next;
    logic [SIZE_INST-1:0] addr;
    logic [1:0]           byte_idx;
    logic [7:0]           csum;
    logic [31:0]          asm_word;
    logic                 load_ok_q;
    logic                 xfer;

    assign xfer    = bus.byte_valid & bus.byte_ready;
    assign wr_next = wr_cnt + 9'd1;
    // A count of zero stands for a full memory image
    assign total   = (n_words == 8'd0) ? (9'd1 << SIZE_INST)
                                       : {1'b0, n_words};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (bus.start) state_nx = COUNT;
            COUNT: if (xfer) state_nx = DATA;
            DATA:  if (xfer && byte_idx == 2'd3) state_nx = WRITE;
            WRITE: state_nx = (wr_next == total) ? CHECK : DATA;
            CHECK: if (xfer) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_words   <= 8'd0;
            wr_cnt    <= 9'd0;
            addr      <= '0;
            byte_idx  <= 2'd0;
            csum      <= 8'd0;
            asm_word  <= 32'd0;
            load_ok_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        load_ok_q <= 1'b0;
                        addr      <= '0;
                        byte_idx  <= 2'd0;
                        csum      <= 8'd0;
                        wr_cnt    <= 9'd0;
                    end
                end
                COUNT: begin
                    if (xfer) n_words <= bus.byte_data;
                end
                DATA: begin
                    if (xfer) begin
                        asm_word <= {bus.byte_data, asm_word[31:8]};
                        csum     <= csum ^ bus.byte_data;
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                WRITE: begin
                    addr   <= addr + 1'b1;
                    wr_cnt <= wr_next;
                end
                CHECK: begin
                    if (xfer) load_ok_q <= (bus.byte_data == csum);
                end
                default: ;
            endcase
        end
    end

    assign bus.byte_ready = (state == COUNT) || (state == DATA) ||
                            (state == CHECK);
    assign bus.imem_we    = (state == WRITE);
    assign bus.imem_waddr = addr;
    assign bus.imem_wdata = asm_word;
    assign bus.busy       = (state != IDLE);
    assign bus.cpu_hold   = (state != IDLE);
    assign bus.done       = (state == DONE);
    assign bus.load_ok    = load_ok_q;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: one instance with 32 words,
// one with 4 words for wrap-around and count-zero loads.
module tb_imem_loader;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [1:0] st = 2'b00;
    logic [1:0] bv = 2'b00;
    logic [7:0] bd [2];

    logic [1:0]  rdy, we, hold, bsy, dn, lok;
    logic [7:0]  wa [2];
    logic [31:0] wd [2];

    logic [31:0] wq [$];
    logic [39:0] exp_q [$];
    logic [31:0] mem5 [32];
    logic [31:0] mem2 [4];

    imem_loader_if #(.SIZE_INST(5)) if5 ();
    imem_loader_if #(.SIZE_INST(2)) if2 ();

    imem_loader #(.SIZE_INST(5)) dut5 (
        .clk(clk), .reset_n(reset_n), .bus(if5.slave)
    );
    imem_loader #(.SIZE_INST(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(if2.slave)
    );

    assign if5.start      = st[0];
    assign if5.byte_valid = bv[0];
    assign if5.byte_data  = bd[0];
    assign if2.start      = st[1];
    assign if2.byte_valid = bv[1];
    assign if2.byte_data  = bd[1];

    assign rdy[0]  = if5.byte_ready;
    assign we[0]   = if5.imem_we;
    assign hold[0] = if5.cpu_hold;
    assign bsy[0]  = if5.busy;
    assign dn[0]   = if5.done;
    assign lok[0]  = if5.load_ok;
    assign wa[0]   = {3'b000, if5.imem_waddr};
    assign wd[0]   = if5.imem_wdata;
    assign rdy[1]  = if2.byte_ready;
    assign we[1]   = if2.imem_we;
    assign hold[1] = if2.cpu_hold;
    assign bsy[1]  = if2.busy;
    assign dn[1]   = if2.done;
    assign lok[1]  = if2.load_ok;
    assign wa[1]   = {6'b000000, if2.imem_waddr};
    assign wd[1]   = if2.imem_wdata;

    always @(posedge clk) begin
        if (if5.imem_we) mem5[if5.imem_waddr] <= if5.imem_wdata;
        if (if2.imem_we) mem2[if2.imem_waddr] <= if2.imem_wdata;
    end

    task automatic send_byte(input int sel, input logic [7:0] b,
                             input int gap_pct);
        logic r;
        bit   sent;
        int   guard;
        sent  = 1'b0;
        guard = 0;
        while (!sent) begin
            @(negedge clk);
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                bv[sel] = 1'b0;
                @(posedge clk);
            end else begin
                bd[sel] = b;
                bv[sel] = 1'b1;
                r = rdy[sel];
                @(posedge clk);
                sent = r;
            end
            guard++;
            if (guard > 500) begin
                failures++;
                $display("FAIL byte_accept_timeout sel=%0d got=no_ready required=ready", sel);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $fatal(1, "byte never accepted");
            end
        end
    endtask

    task automatic run_load(input int sel, input logic [7:0] cnt_byte,
                            input bit bad_chk, input int gap_pct,
                            input int start_at, output int cycles,
                            output int nwr, output logic ok_out);
        int size;
        int nw;
        size   = (sel == 1) ? 4 : 32;
        nw     = (cnt_byte == 8'd0) ? size : int'(cnt_byte);
        cycles = 0;
        nwr    = 0;
        ok_out = 1'bx;
        exp_q.delete();
        @(negedge clk);
        st[sel] = 1'b1;
        @(posedge clk);
        #1 st[sel] = 1'b0;
        fork
            begin
                logic [7:0] cs;
                logic [7:0] bb;
                cs = 8'd0;
                send_byte(sel, cnt_byte, gap_pct);
                for (int w = 0; w < nw; w++) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w * 4 + b == start_at) begin
                            @(negedge clk);
                            bv[sel] = 1'b0;
                            st[sel] = 1'b1;
                            @(negedge clk);
                            st[sel] = 1'b0;
                        end
                        bb = wq[w][8*b +: 8];
                        cs = cs ^ bb;
                        send_byte(sel, bb, gap_pct);
                        if (b == 3)
                            exp_q.push_back({8'(w % size), wq[w]});
                    end
                end
                send_byte(sel, bad_chk ? (cs ^ 8'h01) : cs, gap_pct);
                @(negedge clk);
                bv[sel] = 1'b0;
            end
            begin
                bit   got_done;
                int   cyc;
                logic [39:0] e;
                got_done = 1'b0;
                cyc = 0;
                while (!got_done && cyc < 3000) begin
                    @(negedge clk);
                    cyc++;
                    if (cyc == 1) begin
                        checks++;
                        if ({bsy[sel], hold[sel], rdy[sel], lok[sel]} !== 4'b1110) begin
                            failures++;
                            $display("FAIL start_entry sel=%0d got busy/hold/ready/ok=%b required=1110",
                                     sel, {bsy[sel], hold[sel], rdy[sel], lok[sel]});
                        end
                    end
                    if (we[sel]) begin
                        nwr++;
                        checks++;
                        if (rdy[sel] !== 1'b0) begin
                            failures++;
                            $display("FAIL ready_in_write sel=%0d got=%b required=0", sel, rdy[sel]);
                        end
                        checks++;
                        if (exp_q.size() == 0) begin
                            failures++;
                            $display("FAIL unexpected_write sel=%0d got addr=%0d data=%h required=none",
                                     sel, wa[sel], wd[sel]);
                        end else begin
                            e = exp_q.pop_front();
                            if ({wa[sel], wd[sel]} !== e) begin
                                failures++;
                                $display("FAIL write sel=%0d got addr=%0d data=%h required addr=%0d data=%h",
                                         sel, wa[sel], wd[sel], e[39:32], e[31:0]);
                            end
                        end
                    end
                    if (dn[sel]) begin
                        got_done = 1'b1;
                        cycles = cyc;
                        ok_out = lok[sel];
                        checks++;
                        if (hold[sel] !== 1'b1) begin
                            failures++;
                            $display("FAIL hold_at_done sel=%0d got=%b required=1", sel, hold[sel]);
                        end
                    end
                end
                if (!got_done) begin
                    checks++;
                    failures++;
                    $display("FAIL done_timeout sel=%0d got=no_done required=done", sel);
                end else begin
                    @(negedge clk);
                    checks++;
                    if ({hold[sel], bsy[sel], dn[sel], lok[sel]} !== {3'b000, ok_out}) begin
                        failures++;
                        $display("FAIL after_done sel=%0d got hold/busy/done/ok=%b required=000%b",
                                 sel, {hold[sel], bsy[sel], dn[sel], lok[sel]}, ok_out);
                    end
                end
            end
        join
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_writes sel=%0d got=%0d_left required=0", sel, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bd[0] = 8'h00;
        bd[1] = 8'h00;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if ({rdy[s], we[s], wa[s], wd[s], hold[s], bsy[s], dn[s], lok[s]} !== 46'd0) begin
                failures++;
                $display("FAIL reset_values sel=%0d got rdy=%b we=%b wa=%0d wd=%h hold=%b busy=%b done=%b ok=%b required=all_zero",
                         s, rdy[s], we[s], wa[s], wd[s], hold[s], bsy[s], dn[s], lok[s]);
            end
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_load();
        @(negedge clk);
        st[0] = 1'b1;
        @(posedge clk);
        #1 st[0] = 1'b0;
        send_byte(0, 8'h02, 0);
        send_byte(0, 8'h13, 0);
        send_byte(0, 8'h00, 0);
        @(negedge clk);
        bv[0] = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({rdy[0], we[0], wa[0], wd[0], hold[0], bsy[0], dn[0], lok[0]} !== 46'd0) begin
            failures++;
            $display("FAIL reset_mid_load got rdy=%b we=%b wa=%0d wd=%h hold=%b busy=%b done=%b ok=%b required=all_zero",
                     rdy[0], we[0], wa[0], wd[0], hold[0], bsy[0], dn[0], lok[0]);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_load();
        int cyc;
        int nwr;
        logic ok;
        wq = '{32'h0000_0013, 32'h0010_0093};
        mem5[0] = 32'hdead_beef;
        mem5[1] = 32'hdead_beef;
        run_load(0, 8'h02, 1'b0, 0, -1, cyc, nwr, ok);
        checks++;
        if (cyc != 13) begin
            failures++;
            $display("FAIL basic_duration got=%0d required=13", cyc);
        end
        checks++;
        if (nwr != 2) begin
            failures++;
            $display("FAIL basic_write_count got=%0d required=2", nwr);
        end
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL basic_load_ok got=%b required=1", ok);
        end
        @(negedge clk);
        checks++;
        if (mem5[0] !== 32'h0000_0013 || mem5[1] !== 32'h0010_0093) begin
            failures++;
            $display("FAIL basic_mem got=%h,%h required=00000013,00100093", mem5[0], mem5[1]);
        end
    endtask

    task automatic test_bad_checksum();
        int cyc;
        int nwr;
        logic ok;
        wq = '{32'h0000_0013, 32'h0010_0093};
        run_load(0, 8'h02, 1'b1, 0, -1, cyc, nwr, ok);
        checks++;
        if (ok !== 1'b0 || nwr != 2) begin
            failures++;
            $display("FAIL bad_checksum got ok=%b writes=%0d required ok=0 writes=2", ok, nwr);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        int nwr;
        logic ok;
        wq = '{32'h0000_0013, 32'h0010_0093};
        mem5[0] = 32'h0;
        mem5[1] = 32'h0;
        run_load(0, 8'h02, 1'b0, 40, -1, cyc, nwr, ok);
        checks++;
        if (ok !== 1'b1 || nwr != 2) begin
            failures++;
            $display("FAIL backpressure got ok=%b writes=%0d required ok=1 writes=2", ok, nwr);
        end
        @(negedge clk);
        checks++;
        if (mem5[0] !== 32'h0000_0013 || mem5[1] !== 32'h0010_0093) begin
            failures++;
            $display("FAIL backpressure_mem got=%h,%h required=00000013,00100093", mem5[0], mem5[1]);
        end
    endtask

    task automatic test_wrap_around();
        int cyc;
        int nwr;
        logic ok;
        wq = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
        run_load(1, 8'h05, 1'b0, 20, -1, cyc, nwr, ok);
        checks++;
        if (ok !== 1'b1 || nwr != 5) begin
            failures++;
            $display("FAIL wrap_load got ok=%b writes=%0d required ok=1 writes=5", ok, nwr);
        end
        @(negedge clk);
        checks++;
        if (mem2[0] !== 32'd5 || mem2[1] !== 32'd2 || mem2[2] !== 32'd3 || mem2[3] !== 32'd4) begin
            failures++;
            $display("FAIL wrap_mem got=%h,%h,%h,%h required=5,2,3,4", mem2[0], mem2[1], mem2[2], mem2[3]);
        end
    endtask

    task automatic test_count_zero_ignored_start();
        int cyc;
        int nwr;
        logic ok;
        wq = '{32'hA0A1_A2A3, 32'h1122_3344, 32'hCAFE_F00D, 32'h0BAD_5EED};
        run_load(1, 8'h00, 1'b0, 0, 5, cyc, nwr, ok);
        checks++;
        if (ok !== 1'b1 || nwr != 4) begin
            failures++;
            $display("FAIL count_zero got ok=%b writes=%0d required ok=1 writes=4", ok, nwr);
        end
        @(negedge clk);
        checks++;
        if (mem2[0] !== 32'hA0A1_A2A3 || mem2[1] !== 32'h1122_3344 ||
            mem2[2] !== 32'hCAFE_F00D || mem2[3] !== 32'h0BAD_5EED) begin
            failures++;
            $display("FAIL count_zero_mem got=%h,%h,%h,%h required=a0a1a2a3,11223344,cafef00d,0bad5eed",
                     mem2[0], mem2[1], mem2[2], mem2[3]);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_load();
        test_basic_load();
        test_bad_checksum();
        test_backpressure();
        test_wrap_around();
        test_count_zero_ignored_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
